fpu_host_sequencer: RTL
=======================

# fpu_host_sequencer

Hardware initiator for the FPU's software register interface: accepts one arithmetic command (format, operation, fused flag, up to three operands), drives the `sw_*` bus to program control and operands, rings the doorbell, polls status until ready, reads result and flags, and returns them on a valid/ready response port. It replaces a CPU driver in accelerator-side and verification configurations and connects directly to the FPU top-level `sw_*` ports.

## Interface
Parameters:
- ADDR_CTRL, 32'h00, control register address
- ADDR_OPA / ADDR_OPB / ADDR_OPC, 32'h04 / 32'h08 / 32'h0C, operand addresses
- ADDR_DOORBELL, 32'h10, doorbell register address
- ADDR_STATUS, 32'h14, status register address: [0] ready, [4:1] flags {invalid, overflow, underflow, inexact}
- ADDR_RESULT, 32'h18, result register address
- TIMEOUT_CYCLES, 1024, poll budget in cycles; used only with the timeout feature

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_format  in  2  FPU format code
- cmd_operation  in  2  FPU operation code
- cmd_fused  in  1  fused multiply-add; enables operand C write
- cmd_operand_a / cmd_operand_b / cmd_operand_c  in  32 each  operands
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  response consumer ready
- rsp_result  out  32  FPU result
- rsp_flags  out  4  {invalid, overflow, underflow, inexact}
- rsp_timeout  out  1  poll budget exhausted
- sw_address  out  32  register address
- sw_write_en  out  1  one-cycle write strobe
- sw_read_en  out  1  one-cycle read strobe
- sw_datain  out  32  write data to FPU
- sw_dataout  in  32  read data from FPU, valid the cycle after sw_read_en

## Operation
- Control word: [0] fpu_en=1, [1] fpu_rst, [2] int_en=0, [4:3] format, [6:5] operation, [7] fused; other bits 0.
- Command captured into internal registers on cmd_valid & cmd_ready. Inputs are ignored afterwards.
- FSM states: IDLE, WR_CTRL, WR_A, WR_B, WR_C, WR_DB, POLL_RD, POLL_WAIT, RES_RD, RES_WAIT, DB_CLR, RSP (plus SOFT_RST when the timeout feature is compiled in).
- Write sequence: WR_CTRL → WR_A → WR_B → WR_C (only if fused) → WR_DB. Each state emits a single-cycle write. The doorbell data is 1.
- Poll: POLL_RD strobes a read of ADDR_STATUS. POLL_WAIT samples sw_dataout. If ready, flags are latched from [4:1] and the FSM goes to RES_RD; otherwise it returns to POLL_RD.
- RES_RD strobes a read of ADDR_RESULT. RES_WAIT latches the result.
- DB_CLR writes 0 to ADDR_DOORBELL, then the FSM enters RSP.
- In RSP, rsp_valid is high with stable result, flags and timeout. On rsp_ready the FSM goes to IDLE on the next edge.
- sw_read_en and sw_write_en are never both high. Outside strobe cycles, sw_address and sw_datain are 0.

## Timing
- Reset values: cmd_ready=1 (IDLE), rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_timeout=0, sw_address=0, sw_read_en=0, sw_write_en=0, sw_datain=0. The poll counter is cleared.
- Reset mid-sequence abandons the transaction immediately. No further bus strobes are issued and the FSM is in IDLE on the next cycle.
- Bus outputs are registered and driven in the state cycle.
- Minimum latency, FPU ready on the first poll:
  - Non-fused: rsp_valid rises 10 cycles after the accept edge.
  - Fused: 11 cycles.
  - Each failed poll adds 2 cycles.
- Back-to-back: with rsp_ready held high, RSP lasts one cycle, and cmd_ready is high in the following cycle.
- cmd_valid during a busy state has no effect and is not queued.

## Configuration
- FPU_HOST_TIMEOUT_EN defined:
  - A poll counter counts cycles spent in POLL_RD/POLL_WAIT.
  - On reaching TIMEOUT_CYCLES, the FSM enters SOFT_RST, which writes the control word with fpu_rst=1 and fpu_en=0.
  - It then goes to DB_CLR and RSP with rsp_timeout=1, rsp_result=0, rsp_flags=0.
  - If ready is sampled in the same cycle the count reaches the limit, ready wins.
- Not defined: the FSM polls indefinitely, rsp_timeout is tied to 0, SOFT_RST and the counter are absent.

## Structure
- Shared package fpu_host_pkg holds:
  - the state enum;
  - control-word bit positions;
  - status bit positions;
  - default register addresses;
  - the flag-order constant.
- Optional sub-module fpu_host_watchdog: poll counter with clear, enable and expiry output. It is instantiated only under FPU_HOST_TIMEOUT_EN.

## Test plan
- Non-fused add, format 2'b00, A=32'h3F800000, B=32'h40000000, model returns 32'h40400000 with flags 0 on the first poll → writes in order CTRL=0x01, A, B, DB=1; then status read, result read, DB=0; rsp_valid at cycle 10; rsp_result=32'h40400000.
- Fused command, C=32'h3F800000, cmd_fused=1 → WR_C write to 0x0C precedes the doorbell; bit 7 of CTRL is set; rsp_valid at cycle 11.
- Model not ready for 3 polls, then ready with status 0x13 → 3 extra poll pairs; rsp_flags=4'b1001; latency 16.
- rsp_ready held low for 5 cycles → rsp_valid and data stable throughout; cmd_ready stays 0; a second cmd_valid is ignored.
- Reset asserted during WR_B → next cycle IDLE, no strobes, all outputs at reset values; a fresh command afterwards completes normally.
- With FPU_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, model never ready → SOFT_RST writes CTRL=0x02; rsp_timeout=1; rsp_result=0.

Source files
------------

// File: rtl/fpu_host_pkg.sv
// Shared definitions for the FPU host sequencer: FSM state encoding,
// control/status register bit positions, default register map and the
// flag ordering used on the response port.
// SOFT_RST exists only when FPU_HOST_TIMEOUT_EN is defined.
package fpu_host_pkg;

    // Default register map of the FPU software interface
    localparam logic [31:0] DEF_ADDR_CTRL     = 32'h00;
    localparam logic [31:0] DEF_ADDR_OPA      = 32'h04;
    localparam logic [31:0] DEF_ADDR_OPB      = 32'h08;
    localparam logic [31:0] DEF_ADDR_OPC      = 32'h0C;
    localparam logic [31:0] DEF_ADDR_DOORBELL = 32'h10;
    localparam logic [31:0] DEF_ADDR_STATUS   = 32'h14;
    localparam logic [31:0] DEF_ADDR_RESULT   = 32'h18;
    localparam int          DEF_TIMEOUT_CYCLES = 1024;

    // Control word bit positions
    localparam int CTRL_FPU_EN     = 0;
    localparam int CTRL_FPU_RST    = 1;
    localparam int CTRL_INT_EN     = 2;
    localparam int CTRL_FORMAT_LSB = 3;
    localparam int CTRL_OP_LSB     = 5;
    localparam int CTRL_FUSED      = 7;

    // Status word bit positions
    localparam int STATUS_READY     = 0;
    localparam int STATUS_FLAGS_LSB = 1;

    // Flag vector order: {invalid, overflow, underflow, inexact}
    localparam int FLAG_W         = 4;
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    typedef enum logic [3:0] {
        IDLE,
        WR_CTRL,
        WR_A,
        WR_B,
        WR_C,
        WR_DB,
        POLL_RD,
        POLL_WAIT,
        RES_RD,
        RES_WAIT,
        DB_CLR,
        RSP
`ifdef FPU_HOST_TIMEOUT_EN
        , SOFT_RST
`endif
    } state_t;

    // Command as presented on the input port
    typedef struct packed {
        logic [1:0]  format;
        logic [1:0]  operation;
        logic        fused;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [31:0] operand_c;
    } cmd_t;

    // Part of the command still needed after the control word is written
    typedef struct packed {
        logic        fused;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [31:0] operand_c;
    } operands_t;

    // Control word for a normal operation: enabled, not in reset, no interrupt
    function automatic logic [31:0] ctrl_word(input logic [1:0] format,
                                              input logic [1:0] operation,
                                              input logic       fused);
        logic [31:0] word;
        word                        = '0;
        word[CTRL_FPU_EN]           = 1'b1;
        word[CTRL_FPU_RST]          = 1'b0;
        word[CTRL_INT_EN]           = 1'b0;
        word[CTRL_FORMAT_LSB +: 2]  = format;
        word[CTRL_OP_LSB +: 2]      = operation;
        word[CTRL_FUSED]            = fused;
        return word;
    endfunction

    // Control word that holds the FPU in reset with the datapath disabled
    function automatic logic [31:0] soft_rst_word();
        logic [31:0] word;
        word               = '0;
        word[CTRL_FPU_RST] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/fpu_host_sequencer_if.sv
// Command, response and FPU software-bus signals of the host sequencer.
// The master modport is the sequencer's view (it masters the sw_* bus and
// serves the cmd/rsp ports); the slave modport is the environment's view.
interface fpu_host_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_format;
    logic [1:0]  cmd_operation;
    logic        cmd_fused;
    logic [31:0] cmd_operand_a;
    logic [31:0] cmd_operand_b;
    logic [31:0] cmd_operand_c;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_timeout;

    logic [31:0] sw_address;
    logic        sw_write_en;
    logic        sw_read_en;
    logic [31:0] sw_datain;
    logic [31:0] sw_dataout;

    modport master (
        input  cmd_valid, cmd_format, cmd_operation, cmd_fused,
               cmd_operand_a, cmd_operand_b, cmd_operand_c,
        output cmd_ready,
        output rsp_valid, rsp_result, rsp_flags, rsp_timeout,
        input  rsp_ready,
        output sw_address, sw_write_en, sw_read_en, sw_datain,
        input  sw_dataout
    );

    modport slave (
        output cmd_valid, cmd_format, cmd_operation, cmd_fused,
               cmd_operand_a, cmd_operand_b, cmd_operand_c,
        input  cmd_ready,
        input  rsp_valid, rsp_result, rsp_flags, rsp_timeout,
        output rsp_ready,
        input  sw_address, sw_write_en, sw_read_en, sw_datain,
        output sw_dataout
    );

endinterface

// File: rtl/fpu_host_watchdog.sv
// Poll budget counter for the host sequencer. Counts enabled cycles and
// flags expiry on the cycle in which the LIMIT-th enabled cycle occurs.
// Instantiated only when FPU_HOST_TIMEOUT_EN is defined.
module fpu_host_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    // count holds the number of enabled cycles already completed, so the
    // current cycle is the LIMIT-th one when count equals LIMIT-1
    assign expired = enable && (count == W'(LIMIT - 1));

    // Count enabled cycles; cleared while the sequencer is idle
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fpu_host_sequencer.sv
// Hardware initiator for the FPU software register interface. Accepts one
// command, programs control and operands, rings the doorbell, polls status,
// reads the result, clears the doorbell and returns result/flags on a
// valid/ready response port.
// Optional poll timeout with FPU soft reset: define FPU_HOST_TIMEOUT_EN.
module fpu_host_sequencer
    import fpu_host_pkg::*;
#(
    parameter logic [31:0] ADDR_CTRL      = DEF_ADDR_CTRL,
    parameter logic [31:0] ADDR_OPA       = DEF_ADDR_OPA,
    parameter logic [31:0] ADDR_OPB       = DEF_ADDR_OPB,
    parameter logic [31:0] ADDR_OPC       = DEF_ADDR_OPC,
    parameter logic [31:0] ADDR_DOORBELL  = DEF_ADDR_DOORBELL,
    parameter logic [31:0] ADDR_STATUS    = DEF_ADDR_STATUS,
    parameter logic [31:0] ADDR_RESULT    = DEF_ADDR_RESULT,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic                  clk,
    input logic                  reset,
    fpu_host_sequencer_if.master bus
);

    state_t      state;
    state_t      next_state;

    cmd_t        cmd_in;
    operands_t   operands;
    logic        accept;
    logic        status_ready;

    // Bus values for the cycle about to start, and their registers
    logic [31:0] address_d;
    logic        write_en_d;
    logic        read_en_d;
    logic [31:0] datain_d;
    logic [31:0] address_q;
    logic        write_en_q;
    logic        read_en_q;
    logic [31:0] datain_q;

    logic [31:0]       result_q;
    logic [FLAG_W-1:0] flags_q;

    assign cmd_in = '{
        format:    bus.cmd_format,
        operation: bus.cmd_operation,
        fused:     bus.cmd_fused,
        operand_a: bus.cmd_operand_a,
        operand_b: bus.cmd_operand_b,
        operand_c: bus.cmd_operand_c
    };

    assign accept       = (state == IDLE) && bus.cmd_valid;
    assign status_ready = bus.sw_dataout[STATUS_READY];

`ifdef FPU_HOST_TIMEOUT_EN
    logic polling;
    logic timeout_hit;
    logic timeout_q;

    assign polling = (state == POLL_RD) || (state == POLL_WAIT);

    fpu_host_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == IDLE),
        .enable  (polling),
        .expired (timeout_hit)
    );
`else
    // The poll budget only matters with the timeout feature compiled in
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the bus transfer belonging to the next state
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        next_state = state;
        address_d  = '0;
        write_en_d = 1'b0;
        read_en_d  = 1'b0;
        datain_d   = '0;

        case (state)
            IDLE:      if (bus.cmd_valid) next_state = WR_CTRL;
            WR_CTRL:   next_state = WR_A;
            WR_A:      next_state = WR_B;
            WR_B:      next_state = operands.fused ? WR_C : WR_DB;
            WR_C:      next_state = WR_DB;
            WR_DB:     next_state = POLL_RD;
`ifdef FPU_HOST_TIMEOUT_EN
            POLL_RD:   next_state = timeout_hit ? SOFT_RST : POLL_WAIT;
            // A ready status seen on the expiry cycle still wins
            POLL_WAIT: begin
                if (status_ready)     next_state = RES_RD;
                else if (timeout_hit) next_state = SOFT_RST;
                else                  next_state = POLL_RD;
            end
            SOFT_RST:  next_state = DB_CLR;
`else
            POLL_RD:   next_state = POLL_WAIT;
            POLL_WAIT: next_state = status_ready ? RES_RD : POLL_RD;
`endif
            RES_RD:    next_state = RES_WAIT;
            RES_WAIT:  next_state = DB_CLR;
            DB_CLR:    next_state = RSP;
            RSP:       if (bus.rsp_ready) next_state = IDLE;
            default:   next_state = IDLE;
        endcase

        // Bus outputs are registered, so they are decoded from the state
        // being entered; WR_CTRL is only entered from IDLE, where the
        // command is still on the input port.
        case (next_state)
            WR_CTRL: begin
                write_en_d = 1'b1;
                address_d  = ADDR_CTRL;
                datain_d   = ctrl_word(cmd_in.format, cmd_in.operation, cmd_in.fused);
            end
            WR_A: begin
                write_en_d = 1'b1;
                address_d  = ADDR_OPA;
                datain_d   = operands.operand_a;
            end
            WR_B: begin
                write_en_d = 1'b1;
                address_d  = ADDR_OPB;
                datain_d   = operands.operand_b;
            end
            WR_C: begin
                write_en_d = 1'b1;
                address_d  = ADDR_OPC;
                datain_d   = operands.operand_c;
            end
            WR_DB: begin
                write_en_d = 1'b1;
                address_d  = ADDR_DOORBELL;
                datain_d   = 32'd1;
            end
            POLL_RD: begin
                read_en_d  = 1'b1;
                address_d  = ADDR_STATUS;
            end
            RES_RD: begin
                read_en_d  = 1'b1;
                address_d  = ADDR_RESULT;
            end
            DB_CLR: begin
                write_en_d = 1'b1;
                address_d  = ADDR_DOORBELL;
                datain_d   = 32'd0;
            end
`ifdef FPU_HOST_TIMEOUT_EN
            SOFT_RST: begin
                write_en_d = 1'b1;
                address_d  = ADDR_CTRL;
                datain_d   = soft_rst_word();
            end
`endif
            default: ;
        endcase
    end

    // Bus registers, captured command and response data
    always_ff @(posedge clk) begin
        if (reset) begin
            address_q  <= '0;
            write_en_q <= 1'b0;
            read_en_q  <= 1'b0;
            datain_q   <= '0;
            operands   <= '0;
            result_q   <= '0;
            flags_q    <= '0;
`ifdef FPU_HOST_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            address_q  <= address_d;
            write_en_q <= write_en_d;
            read_en_q  <= read_en_d;
            datain_q   <= datain_d;

            // A new command starts from a clean response, so an aborted
            // (timed-out) run reports zero result and flags
            if (accept) begin
                operands <= '{
                    fused:     cmd_in.fused,
                    operand_a: cmd_in.operand_a,
                    operand_b: cmd_in.operand_b,
                    operand_c: cmd_in.operand_c
                };
                result_q <= '0;
                flags_q  <= '0;
`ifdef FPU_HOST_TIMEOUT_EN
                timeout_q <= 1'b0;
`endif
            end

            if (state == POLL_WAIT && status_ready) begin
                flags_q <= bus.sw_dataout[STATUS_FLAGS_LSB +: FLAG_W];
            end

            if (state == RES_WAIT) begin
                result_q <= bus.sw_dataout;
            end

`ifdef FPU_HOST_TIMEOUT_EN
            if (state == SOFT_RST) begin
                timeout_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.rsp_valid   = (state == RSP);
    assign bus.rsp_result  = result_q;
    assign bus.rsp_flags   = flags_q;
`ifdef FPU_HOST_TIMEOUT_EN
    assign bus.rsp_timeout = timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    assign bus.sw_address  = address_q;
    assign bus.sw_write_en = write_en_q;
    assign bus.sw_read_en  = read_en_q;
    assign bus.sw_datain   = datain_q;

endmodule
